// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg : shared widths, reset constants and the fetch entry type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_inst_fifo.sv
// ---------------------------------------------------------------------------
// ifu_inst_fifo : DEPTH-entry FIFO of fetch entries with flush and occupancy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_inst_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enq,
    input  fetch_entry_t           i_enq_data,
    input  logic                   i_deq,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_enq;
    logic w_do_deq;

    // Flush dominates: anything offered in the flush cycle is discarded.
    assign w_do_enq = i_enq && !i_flush;
    assign w_do_deq = i_deq && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_enq) r_mem[r_wr_ptr] <= i_enq_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_do_enq && (r_count == C_FULL)));

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch : sequential instruction fetch with credit-limited requests,
//             in-order response buffering and redirect flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] C_DEPTH = SW'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_live_cnt;
    logic [CW-1:0]   r_stale_cnt;

    logic [CW-1:0]   w_count;
    logic [SW-1:0]   w_inflight;
    logic            w_req_fire;
    logic            w_resp_keep;
    logic            w_resp_drop;
    logic            w_deq;
    fetch_entry_t    w_enq_data;
    fetch_entry_t    w_head;

    // Buffered + kept-in-flight + to-be-dropped never exceeds DEPTH, so the
    // FIFO always has room for every response it will keep.
    assign w_inflight = SW'(w_count) + SW'(r_live_cnt) + SW'(r_stale_cnt);

    assign imem_req_valid = rst && !redirect_valid && (w_inflight < C_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_stale_cnt != '0);
    assign w_resp_keep = imem_resp_valid && (r_stale_cnt == '0) && !redirect_valid;
    assign w_deq       = out_valid && out_ready && !redirect_valid;

    // Kept responses arrive in request order, so their pc is a running counter.
    assign w_enq_data.pc   = r_resp_pc;
    assign w_enq_data.inst = imem_resp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_pc   <= RESET_PC;
            r_live_cnt  <= '0;
            r_stale_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc  <= align_pc(redirect_pc);
            r_resp_pc   <= align_pc(redirect_pc);
            r_live_cnt  <= '0;
            r_stale_cnt <= r_stale_cnt + r_live_cnt - CW'(imem_resp_valid);
        end else begin
            if (w_req_fire)  r_fetch_pc <= r_fetch_pc + 64'd4;
            if (w_resp_keep) r_resp_pc  <= r_resp_pc + 64'd4;
            r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_resp_keep);
            if (w_resp_drop) r_stale_cnt <= r_stale_cnt - 1'b1;
        end
    end

    ifu_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .i_enq      (w_resp_keep),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .i_flush    (redirect_valid),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_inst  = out_valid ? w_head.inst : NOP_INST;
    assign out_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch : directed bench for ifu_fetch with a latency-programmable memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1234_0000;
    endfunction

    // Memory: in-order, fixed latency 'lat' cycles from acceptance to response.
    int          lat = 1;
    int          cyc = 0;
    logic [63:0] pend_a[$];
    int          pend_t[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_a.delete();
            pend_t.delete();
            cyc = 0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_a.push_back(imem_req_addr);
                pend_t.push_back(cyc);
            end
            imem_resp_valid <= 1'b0;
            if (pend_t.size() > 0 && (pend_t[0] + lat - 1) <= cyc) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_word(pend_a[0]);
                void'(pend_a.pop_front());
                void'(pend_t.pop_front());
            end
            cyc = cyc + 1;
        end
    end

    // Stream monitor: request addresses and output pc/inst follow +4 sequences.
    logic [63:0] exp_req = RST_PC;
    logic [63:0] exp_out = RST_PC;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            exp_req = RST_PC;
            exp_out = RST_PC;
        end else if (redirect_valid) begin
            check_val("mon_req_blocked", {63'd0, imem_req_valid}, 64'd0);
            exp_req = {redirect_pc[63:2], 2'b00};
            exp_out = {redirect_pc[63:2], 2'b00};
        end else begin
            if (imem_req_valid) check_val("mon_req_addr", imem_req_addr, exp_req);
            if (imem_req_valid && imem_req_ready) exp_req = exp_req + 64'd4;
            if (out_valid) begin
                check_val("mon_out_pc", out_pc, exp_out);
                check_val("mon_out_inst", {32'd0, out_inst}, {32'd0, mem_word(exp_out)});
                if (out_ready) exp_out = exp_out + 64'd4;
            end
        end
    end

    task automatic do_reset(input int latency, input logic rdy);
        @(posedge clk); #1;
        rst            = 1'b0;
        lat            = latency;
        imem_req_ready = rdy;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_out_valid(input string tag, input int max);
        int i = 0;
        @(negedge clk);
        while (!out_valid && i < max) begin
            @(negedge clk);
            i++;
        end
        check_val({tag, "_seen"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic wait_req_valid(input string tag, input int max);
        int i = 0;
        @(negedge clk);
        while (!imem_req_valid && i < max) begin
            @(negedge clk);
            i++;
        end
        check_val({tag, "_seen"}, {63'd0, imem_req_valid}, 64'd1);
    endtask

    initial begin
        int  nreq;
        bit  found;

        // Reset state
        @(negedge clk);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Streaming, memory always ready, latency 1
        @(negedge clk);
        check_val("t1_first_valid", {63'd0, imem_req_valid}, 64'd1);
        check_val("t1_first_addr", imem_req_addr, 64'h8000_0000);
        @(negedge clk);
        check_val("t1_c1_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("t1_second_addr", imem_req_addr, 64'h8000_0004);
        @(negedge clk);
        check_val("t1_c2_out_valid", {63'd0, out_valid}, 64'd1);
        check_val("t1_c2_pc", out_pc, 64'h8000_0000);
        check_val("t1_c2_inst", {32'd0, out_inst}, 64'h9234_0000);
        repeat (12) @(negedge clk);

        // Core stalled: credit cap limits issue to DEPTH requests
        out_ready = 1'b0;
        do_reset(1, 1'b1);
        nreq = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        check_val("t2_req_count", 64'(nreq), 64'd2);
        check_val("t2_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check_val("t2_out_valid", {63'd0, out_valid}, 64'd1);
        check_val("t2_out_pc", out_pc, 64'h8000_0000);
        check_val("t2_out_inst", {32'd0, out_inst}, 64'h9234_0000);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);

        // Redirect with two requests outstanding (latency 3)
        do_reset(3, 1'b1);
        @(negedge clk);
        check_val("t3_addr0", imem_req_addr, 64'h8000_0000);
        @(negedge clk);
        check_val("t3_addr1_valid", {63'd0, imem_req_valid}, 64'd1);
        check_val("t3_addr1", imem_req_addr, 64'h8000_0004);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1003;
        @(negedge clk);
        check_val("t3_req_blocked", {63'd0, imem_req_valid}, 64'd0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_req_valid("t3_req", 10);
        check_val("t3_new_addr", imem_req_addr, 64'h8000_1000);
        wait_out_valid("t3_out", 20);
        check_val("t3_out_pc", out_pc, 64'h8000_1000);
        check_val("t3_out_inst", {32'd0, out_inst}, 64'h9234_1000);

        // Redirect coinciding with a response and an output handshake
        do_reset(1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && imem_resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t4_collision_found", {63'd0, found}, 64'd1);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check_val("t4_flushed", {63'd0, out_valid}, 64'd0);
        check_val("t4_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_val("t4_req_addr", imem_req_addr, 64'h8000_2000);
        wait_out_valid("t4_out", 10);
        check_val("t4_out_pc", out_pc, 64'h8000_2000);
        check_val("t4_out_inst", {32'd0, out_inst}, 64'h9234_2000);

        // Memory not ready: request held stable
        do_reset(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t5_hold_valid", {63'd0, imem_req_valid}, 64'd1);
            check_val("t5_hold_addr", imem_req_addr, 64'h8000_0000);
        end
        @(posedge clk); #1 imem_req_ready = 1'b1;
        @(negedge clk);
        check_val("t5_release_addr", imem_req_addr, 64'h8000_0000);
        wait_out_valid("t5_out", 10);
        check_val("t5_out_pc", out_pc, 64'h8000_0000);

        // 64-bit pc wrap across a redirect to the top of the address space
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_out_valid("t6_top", 10);
        check_val("t6_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("t6_top_inst", {32'd0, out_inst}, 64'hEDCB_FFFC);
        @(posedge clk); #1;
        wait_out_valid("t6_wrap", 10);
        check_val("t6_wrap_pc", out_pc, 64'h0);
        check_val("t6_wrap_inst", {32'd0, out_inst}, 64'h1234_0000);

        // Back-to-back redirects: the last target wins
        do_reset(3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_3000;
        @(posedge clk); #1 redirect_pc = 64'h0000_0000_8000_4004;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_out_valid("t7_out", 30);
        check_val("t7_out_pc", out_pc, 64'h8000_4004);
        check_val("t7_out_inst", {32'd0, out_inst}, 64'h9234_4004);

        // Asynchronous reset in the middle of a cycle
        do_reset(1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && imem_req_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t8_busy_found", {63'd0, found}, 64'd1);
        #1 rst = 1'b0;
        #1;
        check_val("t8_async_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("t8_async_req_valid", {63'd0, imem_req_valid}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_val("t8_restart_valid", {63'd0, imem_req_valid}, 64'd1);
        check_val("t8_restart_addr", imem_req_addr, 64'h8000_0000);
        wait_out_valid("t8_out", 10);
        check_val("t8_out_pc", out_pc, 64'h8000_0000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
